// File: rtl/relu_arbiter.sv
// Two-requester arbiter feeding a single ReLU output register, with burst
// limiting, alternating priority on contention and a saturating clamp counter.
//
// state  | meaning
// IDLE   | no grant; arbitrate from reqN_valid, grant takes effect next cycle
// GRANT0 | requester 0 owns the datapath until last beat or burst limit
// GRANT1 | requester 1 owns the datapath until last beat or burst limit
module relu_arbiter #(
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_last,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_last,
   output logic              req1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_id,
   output logic              out_last,
   input  logic              out_ready,
   output logic [15:0]       clamp_cnt
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t            state;
   logic              prio;
   logic [7:0]        burst_cnt;
   logic              out_free;
   logic              gnt_id;
   logic              acc_valid;
   logic [DATA_W-1:0] acc_data;
   logic              acc_last;
   logic              accept;
   logic              acc_neg;

   // The output slot is free when empty or being drained this same cycle.
   assign out_free   = !out_valid || out_ready;
   assign req0_ready = (state == GRANT0) && out_free;
   assign req1_ready = (state == GRANT1) && out_free;

   assign gnt_id    = (state == GRANT1);
   assign acc_valid = gnt_id ? req1_valid : req0_valid;
   assign acc_data  = gnt_id ? req1_data  : req0_data;
   assign acc_last  = gnt_id ? req1_last  : req0_last;
   assign accept    = (state != IDLE) && acc_valid && out_free;
   assign acc_neg   = acc_data[DATA_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prio      <= 1'b0;
         burst_cnt <= 8'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= 1'b0;
         out_last  <= 1'b0;
         clamp_cnt <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid && (!req1_valid || !prio)) begin
                  state     <= GRANT0;
                  prio      <= 1'b1;
                  burst_cnt <= 8'd0;
               end else if (req1_valid) begin
                  state     <= GRANT1;
                  prio      <= 1'b0;
                  burst_cnt <= 8'd0;
               end
            end
            GRANT0, GRANT1: begin
               if (accept) begin
                  burst_cnt <= burst_cnt + 8'd1;
                  // Burst-limit release keeps the packet open; the requester
                  // resumes it on a later grant.
                  if (acc_last || (burst_cnt == BURST_LAST))
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= acc_neg ? '0 : acc_data;
            out_id    <= gnt_id;
            out_last  <= acc_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept && acc_neg && (clamp_cnt != 16'hFFFF))
            clamp_cnt <= clamp_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_relu_arbiter.sv
// Self-checking bench for relu_arbiter: scoreboard on every output beat, a
// ReLU vector table, directed multi-cycle sequences and a clamp saturation run.
module tb_relu_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
   logic [31:0] req0_data, req1_data, out_data;
   logic        out_valid, out_id, out_last, out_ready;
   logic [15:0] clamp_cnt;

   logic        s_rst, s_req0_valid, s_req0_last, s_req0_ready, s_req1_valid, s_req1_last, s_req1_ready;
   logic [31:0] s_req0_data, s_req1_data, s_out_data;
   logic        s_out_valid, s_out_id, s_out_last, s_out_ready;
   logic [15:0] s_clamp;

   relu_arbiter #(.DATA_W(32), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
      .out_ready(out_ready), .clamp_cnt(clamp_cnt));

   relu_arbiter #(.DATA_W(32), .MAX_BURST(255)) dut_sat (
      .clk(clk), .rst(s_rst),
      .req0_valid(s_req0_valid), .req0_data(s_req0_data), .req0_last(s_req0_last), .req0_ready(s_req0_ready),
      .req1_valid(s_req1_valid), .req1_data(s_req1_data), .req1_last(s_req1_last), .req1_ready(s_req1_ready),
      .out_valid(s_out_valid), .out_data(s_out_data), .out_id(s_out_id), .out_last(s_out_last),
      .out_ready(s_out_ready), .clamp_cnt(s_clamp));

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        last;
      int          cyc;
   } obs_t;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   typedef logic [31:0] warr_t [8];

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   beat_t       sb[$];
   obs_t        out_log[$];
   logic [15:0] exp_clamp = 16'd0;
   bit          sat_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic id, input logic [31:0] d, input logic l);
      beat_t b;
      b.id   = id;
      b.data = d[31] ? 32'h0 : d;
      b.last = l;
      sb.push_back(b);
      if (d[31] && exp_clamp != 16'hFFFF) exp_clamp = exp_clamp + 16'd1;
   endtask

   // Scoreboard: inputs accepted at the coming edge are pushed, outputs
   // taken at the coming edge are popped and compared.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_clamp = 16'd0;
      end else begin
         if (out_valid && out_ready) begin
            obs_t o;
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_unexpected_beat: got data %h id %0d with no beat expected", out_data, out_id);
            end else begin
               beat_t e;
               e = sb.pop_front();
               check("sb_data", out_data, e.data);
               check("sb_id", out_id, e.id);
               check("sb_last", out_last, e.last);
            end
            o.id = out_id; o.data = out_data; o.last = out_last; o.cyc = cyc;
            out_log.push_back(o);
         end
         if (req0_valid && req0_ready) push_exp(1'b0, req0_data, req0_last);
         if (req1_valid && req1_ready) push_exp(1'b1, req1_data, req1_last);
      end
   end

   function automatic warr_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic [31:0] d, input logic [31:0] e, input logic [31:0] f);
      warr_t w;
      w = '{default: 32'h0};
      w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f;
      return w;
   endfunction

   task automatic drive(input logic id, input logic v, input logic [31:0] d, input logic l);
      if (id) begin
         req1_valid = v; req1_data = d; req1_last = l;
      end else begin
         req0_valid = v; req0_data = d; req0_last = l;
      end
   endtask

   task automatic send_pkt(input logic id, input int n, input warr_t d, input bit last_end);
      for (int i = 0; i < n; i++) begin
         int k;
         drive(id, 1'b1, d[i], last_end && (i == n - 1));
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!(id ? req1_ready : req0_ready) && k < 200);
         if (k >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: requester %0d beat %0d never accepted", id, i);
         end
         @(posedge clk); #1;
      end
      drive(id, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic wait_out(input int n, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (out_log.size() >= n) break;
         @(negedge clk);
      end
      if (out_log.size() < n) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_out_timeout: got %0d beats required %0d", out_log.size(), n);
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   vec_t  tbl[8];
   int    base;
   logic  exp_ids[8];
   logic [31:0] exp_dat[8];
   int    exp_gap[7];

   initial begin
      tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
      tbl[1] = '{1'b1, 32'h8000_0000, 32'h0000_0000};
      tbl[2] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[4] = '{1'b1, 32'h0000_0001, 32'h0000_0001};
      tbl[5] = '{1'b0, 32'h1234_5678, 32'h1234_5678};
      tbl[6] = '{1'b0, 32'hC000_0000, 32'h0000_0000};
      tbl[7] = '{1'b1, 32'h4000_0000, 32'h4000_0000};

      rst = 1'b1; out_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 32'h1; req0_last = 1'b0;
      req1_valid = 1'b1; req1_data = 32'h2; req1_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      check("rst_out_last", out_last, 0);
      check("rst_clamp", clamp_cnt, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // single requester, two-beat packet
      out_log.delete();
      send_pkt(1'b0, 2, mk(32'h5, 32'hFFFF_FFFB, 0, 0, 0, 0), 1'b1);
      wait_out(2, 20);
      check("t1_d0", out_log[0].data, 32'h5);
      check("t1_id0", out_log[0].id, 0);
      check("t1_last0", out_log[0].last, 0);
      check("t1_d1", out_log[1].data, 32'h0);
      check("t1_last1", out_log[1].last, 1);
      check("t1_latency_gap", out_log[1].cyc - out_log[0].cyc, 1);
      check("t1_clamp", clamp_cnt, 16'd1);

      // table of single-beat packets
      for (int i = 0; i < 8; i++) begin
         base = out_log.size();
         send_pkt(tbl[i].id, 1, mk(tbl[i].data, 0, 0, 0, 0, 0), 1'b1);
         wait_out(base + 1, 20);
         check("tbl_data", out_log[base].data, tbl[i].exp);
         check("tbl_id", out_log[base].id, tbl[i].id);
         check("tbl_last", out_log[base].last, 1);
      end
      @(negedge clk);
      check("tbl_clamp", clamp_cnt, 16'd4);
      check("tbl_clamp_model", clamp_cnt, exp_clamp);

      // contention from reset: alternating packets with an IDLE cycle between
      @(posedge clk); #1;
      pulse_reset();
      out_log.delete();
      fork
         begin
            send_pkt(1'b0, 2, mk(32'h10, 32'h11, 0, 0, 0, 0), 1'b1);
            send_pkt(1'b0, 2, mk(32'h12, 32'h13, 0, 0, 0, 0), 1'b1);
         end
         begin
            send_pkt(1'b1, 2, mk(32'h20, 32'hFFFF_0000, 0, 0, 0, 0), 1'b1);
            send_pkt(1'b1, 2, mk(32'h22, 32'h23, 0, 0, 0, 0), 1'b1);
         end
      join
      wait_out(8, 20);
      exp_ids = '{0, 0, 1, 1, 0, 0, 1, 1};
      exp_dat = '{32'h10, 32'h11, 32'h20, 32'h0, 32'h12, 32'h13, 32'h22, 32'h23};
      exp_gap = '{1, 2, 1, 2, 1, 2, 1};
      for (int i = 0; i < 8; i++) begin
         check("cont_id", out_log[i].id, exp_ids[i]);
         check("cont_data", out_log[i].data, exp_dat[i]);
      end
      for (int i = 0; i < 7; i++)
         check("cont_gap", out_log[i+1].cyc - out_log[i].cyc, exp_gap[i]);

      // backpressure for three cycles on the first beat
      repeat (2) @(posedge clk);
      #1;
      out_log.delete();
      fork
         send_pkt(1'b0, 3, mk(32'h31, 32'hFFFF_FFF0, 32'h33, 0, 0, 0), 1'b1);
         begin
            for (int k = 0; k < 50; k++) begin
               @(posedge clk); #1;
               if (out_valid) break;
            end
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_valid", out_valid, 1);
               check("bp_data", out_data, 32'h31);
               check("bp_ready0", req0_ready, 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_out(3, 20);
      repeat (3) @(negedge clk);
      check("bp_count", out_log.size(), 3);
      check("bp_d1", out_log[1].data, 32'h0);
      check("bp_d2", out_log[2].data, 32'h33);
      check("bp_last2", out_log[2].last, 1);

      // burst limit of 4 on a 6-beat packet
      out_log.delete();
      send_pkt(1'b1, 6, mk(32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56), 1'b1);
      wait_out(6, 20);
      exp_gap = '{1, 1, 1, 2, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
         check("burst_id", out_log[i].id, 1);
         check("burst_data", out_log[i].data, 32'h51 + i);
         check("burst_last", out_log[i].last, (i == 5) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++)
         check("burst_gap", out_log[i+1].cyc - out_log[i].cyc, exp_gap[i]);

      // reset after first of three beats
      out_log.delete();
      drive(1'b0, 1'b1, 32'hFFFF_FF00, 1'b0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req0_ready) break;
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h61, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_clamp", clamp_cnt, 0);
      check("mid_rst_ready0", req0_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      send_pkt(1'b1, 2, mk(32'h71, 32'h8000_0005, 0, 0, 0, 0), 1'b1);
      wait_out(2, 20);
      repeat (3) @(negedge clk);
      check("post_rst_count", out_log.size(), 2);
      check("post_rst_d0", out_log[0].data, 32'h71);
      check("post_rst_id0", out_log[0].id, 1);
      check("post_rst_d1", out_log[1].data, 32'h0);
      check("post_rst_clamp", clamp_cnt, 16'd1);

      for (int k = 0; k < 80000; k++) begin
         if (sat_done) break;
         @(posedge clk);
      end
      if (!sat_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sat_timeout: saturation run did not complete");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Clamp saturation: a long stream of negative beats on a separate instance.
   initial begin
      int s_acc;
      s_acc = 0;
      s_rst = 1'b1; s_out_ready = 1'b1;
      s_req0_valid = 1'b0; s_req0_data = 32'h8000_0001; s_req0_last = 1'b0;
      s_req1_valid = 1'b0; s_req1_data = 32'h0; s_req1_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      s_rst = 1'b0;
      s_req0_valid = 1'b1;
      for (int k = 0; k < 70000; k++) begin
         @(negedge clk);
         if (s_acc == 1000) check("sat_clamp_1000", s_clamp, 16'd1000);
         if (s_acc == 65535) check("sat_clamp_max", s_clamp, 16'hFFFF);
         if (s_req0_valid && s_req0_ready) s_acc++;
         if (s_acc >= 65600) break;
      end
      @(negedge clk);
      check("sat_beats", (s_acc >= 65600) ? 1 : 0, 1);
      check("sat_clamp_hold", s_clamp, 16'hFFFF);
      sat_done = 1'b1;
   end

endmodule

// File: doc/relu_arbiter.md
RELU_ARBITER -- requirements
Module: relu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of operand and result words (two's-complement sign in bit DATA_W-1).
REQ-002 Parameter: MAX_BURST, default 16, maximum beats granted to one requester before forced re-arbitration (range 1..255).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; reset is synchronous and active-high.
REQ-005 Port: req0_valid / req1_valid  input  1  requester n offers a beat.
REQ-006 Port: req0_data / req1_data  input  DATA_W  operand from requester n.
REQ-007 Port: req0_last / req1_last  input  1  beat is final beat of requester n's packet.
REQ-008 Port: req0_ready / req1_ready  output  1  beat from requester n accepted this cycle when valid&ready.
REQ-009 Port: out_valid  output  1  result register holds a beat.
REQ-010 Port: out_data  output  DATA_W  ReLU result.
REQ-011 Port: out_id  output  1  requester index that produced the beat.
REQ-012 Port: out_last  output  1  copy of the accepted beat's last flag.
REQ-013 Port: out_ready  input  1  downstream accepts the beat when out_valid&out_ready.
REQ-014 Port: clamp_cnt  output  16  saturating count of beats whose operand was negative.

Function
REQ-015 FSM states SHALL be IDLE, GRANT0, GRANT1; one-hot or binary encoding is free.
REQ-016 In IDLE, req*_ready SHALL be 0; arbitration decided from req*_valid that cycle; grant state entered next cycle.
REQ-017 Arbitration in IDLE: only one valid -> grant it; both valid -> grant requester selected by priority pointer prio; none -> stay IDLE.
REQ-018 prio SHALL point to the requester not most recently granted; updated on every IDLE->GRANTx transition to the other index.
REQ-019 In GRANTx, reqx_ready SHALL equal (!out_valid | out_ready); the non-granted ready SHALL be 0.
REQ-020 Accepted beat SHALL load output register next cycle: out_data = operand if sign bit 0, else all zeros; out_id = x; out_last = reqx_last; out_valid = 1.
REQ-021 Latency: exactly 1 cycle from acceptance to out_valid, with out_ready held high sustaining one beat per cycle.
REQ-022 out_valid SHALL fall only when out_valid&out_ready and no new beat accepted in the same cycle; out_* held stable while out_valid&!out_ready.
REQ-023 burst_cnt (8-bit) SHALL reset to 0 on entering GRANTx and increment per accepted beat.
REQ-024 GRANTx -> IDLE on the cycle a beat is accepted with reqx_last=1 or burst_cnt reaching MAX_BURST (beat counted inclusive).
REQ-025 Forced release (MAX_BURST) SHALL NOT alter out_last; packet resumes on a later grant.
REQ-026 In GRANTx with reqx_valid=0, state SHALL hold (no timeout).
REQ-027 clamp_cnt SHALL increment by 1 per accepted beat with negative operand; saturate at 16'hFFFF.
REQ-028 Operand 0 and most-negative value: 0 passes as 0; 0x80000000 -> 0.

Reset
REQ-029 While rst=1 at a clk edge: state=IDLE, prio=0, burst_cnt=0, out_valid=0, out_data=0, out_id=0, out_last=0, clamp_cnt=0; req*_ready=0 the cycle after.
REQ-030 Reset mid-packet SHALL discard the in-flight result register and grant; no beat emitted after reset from prior traffic.

Verification
REQ-031 Single requester: req0 sends 0x00000005, 0xFFFFFFFB(last), out_ready=1 -> out 0x5 id0, then 0x0 id0 last, clamp_cnt=1.
REQ-032 Contention: both valid from reset, 2-beat packets each -> req0 packet first, IDLE cycle, then req1 packet; order repeats alternately.
REQ-033 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, granted ready=0, no beat lost/duplicated.
REQ-034 MAX_BURST=4, req1 streams 6 beats, req0 idle -> grant released after beat 4, IDLE cycle, re-granted for beats 5-6.
REQ-035 rst asserted after 1 of 3 beats accepted -> out_valid=0, clamp_cnt=0 next cycle, new packet from req1 processed normally.
REQ-036 Clamp saturation: preload via 65536 negative beats -> clamp_cnt stays 16'hFFFF.
